// File: rtl/gpio_seq_pkg.sv
// Shared types and constants for the AHB GPIO sequencer: FSM state
// encoding, GPIO register offsets, AHB transfer encodings and a small
// helper that maps an operation onto the GPIO direction it needs.
package gpio_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIR_A  = 3'd1,
        ST_DIR_D  = 3'd2,
        ST_XFER_A = 3'd3,
        ST_XFER_D = 3'd4,
        ST_ACK    = 3'd5
    } seq_state_e;

    localparam logic [31:0] OFS_DATA = 32'h0000_0000;
    localparam logic [31:0] OFS_DIR  = 32'h0000_0004;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // A write drives the pins (output direction), a read samples them.
    function automatic logic [15:0] dir_for_op(input logic        is_write,
                                               input logic [15:0] dir_out,
                                               input logic [15:0] dir_in);
        return is_write ? dir_out : dir_in;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the requester that
// currently has priority; on an update strobe it moves to the requester
// that was not granted, so simultaneous requests alternate.
module rr_arb2
    import gpio_seq_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic ptr_r;

    // One-hot grant: the priority requester if it asks, otherwise the other one.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b00) begin
            grant = 2'b00;
        end else if (ptr_r == 1'b0) begin
            grant = req[0] ? 2'b01 : 2'b10;
        end else begin
            grant = req[1] ? 2'b10 : 2'b01;
        end
    end

    // Priority pointer: hand priority to the requester that was not just served.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ptr_r <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            ptr_r <= grant[0];
        end
    end

endmodule

// File: rtl/ahb_gpio_sequencer.sv
// AHB-Lite master sharing one GPIO slave between two requesters.
// Each granted request becomes an optional direction-register write
// (only when the cached direction differs) followed by one data-register
// access, then a one-cycle ack. All bus outputs are registered and held
// while HREADY is low; address and data phases never overlap.
module ahb_gpio_sequencer
    import gpio_seq_pkg::*;
#(
    parameter logic [31:0] GPIO_BASE = 32'h5300_0000,
    parameter logic [15:0] DIR_OUT   = 16'h0001,
    parameter logic [15:0] DIR_IN    = 16'h0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  req,
    input  logic [1:0]  req_write,
    input  logic [31:0] req_wdata,
    output logic [1:0]  ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    output logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    seq_state_e  state_r;
    logic        grant_idx_r;
    logic        op_write_r;
    logic [15:0] wdata_r;
    logic [15:0] dir_q_r;

    logic [1:0]  grant_s;
    logic        arb_update_s;
    logic        sel_write_s;
    logic [15:0] sel_wdata_s;
    logic [15:0] sel_dir_s;
    logic [15:0] need_dir_s;
    logic [15:0] hrdata_unused_s;

    assign HSIZE           = HSIZE_WORD;
    assign hrdata_unused_s = HRDATA[31:16];
    assign arb_update_s    = (state_r == ST_IDLE) && (req != 2'b00);
    assign sel_dir_s       = dir_for_op(sel_write_s, DIR_OUT, DIR_IN);
    assign need_dir_s      = dir_for_op(op_write_r, DIR_OUT, DIR_IN);

    rr_arb2 u_arb (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req     (req),
        .update  (arb_update_s),
        .grant   (grant_s)
    );

    // Operands of the requester the arbiter is granting this cycle.
    always_comb begin
        sel_write_s = 1'b0;
        sel_wdata_s = 16'h0000;
        if (grant_s[1]) begin
            sel_write_s = req_write[1];
            sel_wdata_s = req_wdata[31:16];
        end else begin
            sel_write_s = req_write[0];
            sel_wdata_s = req_wdata[15:0];
        end
    end

    // Sequencer FSM with registered AHB outputs, ack and read data.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            grant_idx_r <= 1'b0;
            op_write_r  <= 1'b0;
            wdata_r     <= 16'h0000;
            dir_q_r     <= DIR_IN;
            ack         <= 2'b00;
            rdata       <= 16'h0000;
            busy        <= 1'b0;
            HADDR       <= GPIO_BASE;
            HTRANS      <= HTRANS_IDLE;
            HWRITE      <= 1'b0;
            HWDATA      <= 32'h0000_0000;
            HSEL        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant_idx_r <= grant_s[1];
                        op_write_r  <= sel_write_s;
                        wdata_r     <= sel_wdata_s;
                        busy        <= 1'b1;
                        HSEL        <= 1'b1;
                        HTRANS      <= HTRANS_NONSEQ;
                        if (sel_dir_s != dir_q_r) begin
                            state_r <= ST_DIR_A;
                            HADDR   <= GPIO_BASE + OFS_DIR;
                            HWRITE  <= 1'b1;
                        end else begin
                            state_r <= ST_XFER_A;
                            HADDR   <= GPIO_BASE + OFS_DATA;
                            HWRITE  <= sel_write_s;
                        end
                    end
                end
                ST_DIR_A: begin
                    if (HREADY) begin
                        state_r <= ST_DIR_D;
                        HSEL    <= 1'b0;
                        HTRANS  <= HTRANS_IDLE;
                        HWDATA  <= {16'h0000, need_dir_s};
                    end
                end
                ST_DIR_D: begin
                    if (HREADY) begin
                        state_r <= ST_XFER_A;
                        dir_q_r <= need_dir_s;
                        HWDATA  <= 32'h0000_0000;
                        HSEL    <= 1'b1;
                        HTRANS  <= HTRANS_NONSEQ;
                        HADDR   <= GPIO_BASE + OFS_DATA;
                        HWRITE  <= op_write_r;
                    end
                end
                ST_XFER_A: begin
                    if (HREADY) begin
                        state_r <= ST_XFER_D;
                        HSEL    <= 1'b0;
                        HTRANS  <= HTRANS_IDLE;
                        HWDATA  <= op_write_r ? {16'h0000, wdata_r} : 32'h0000_0000;
                    end
                end
                ST_XFER_D: begin
                    if (HREADY) begin
                        state_r <= ST_ACK;
                        if (!op_write_r) begin
                            rdata <= HRDATA[15:0];
                        end
                        HWDATA  <= 32'h0000_0000;
                        HADDR   <= GPIO_BASE;
                        HWRITE  <= 1'b0;
                        ack     <= grant_idx_r ? 2'b10 : 2'b01;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    ack     <= 2'b00;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack     <= 2'b00;
                    busy    <= 1'b0;
                    HADDR   <= GPIO_BASE;
                    HTRANS  <= HTRANS_IDLE;
                    HWRITE  <= 1'b0;
                    HWDATA  <= 32'h0000_0000;
                    HSEL    <= 1'b0;
                end
            endcase
        end
    end

endmodule
